park_exit_cashier: RTL and testbench

//  Exit-side controller of the car park. It reads the entry timestamp from the ticket of a car at the exit

---
 rtl/park_exit_cashier.sv | 133 +++++++++++++
 tb/tb_park_exit_cashier.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/park_exit_cashier.sv
// park_exit_cashier: exit-side fee, payment and bar controller; define PARK_GRACE_EN for a free-parking window
module park_exit_cashier #(
  parameter int TW           = 16,
  parameter int COST_W       = 16,
  parameter int FEE_PER_UNIT = 2,
  parameter int BAR_HOLD     = 8,
  parameter int GRACE        = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sout,
  input  logic [TW-1:0]     now_time,
  input  logic              tkt_valid,
  input  logic [TW-1:0]     tkt_time,
  output logic              tkt_ready,
  input  logic              pay_valid,
  input  logic [COST_W-1:0] pay_amount,
  output logic [COST_W-1:0] cost,
  output logic              cost_valid,
  output logic [COST_W-1:0] change,
  output logic              bout,
  output logic              car_left
);
`ifdef PARK_GRACE_EN
  localparam bit GRACE_ON = 1'b1;
`else
  localparam bit GRACE_ON = 1'b0;
`endif
  localparam int HW = $clog2(BAR_HOLD + 2);
  localparam int PW = TW + COST_W;
  typedef enum logic [2:0] {IDLE, WAIT_TKT, CALC, WAIT_PAY, OPEN} state_t;
  state_t state, state_n;
  logic [TW-1:0] tkt_q, tkt_q_n, elapsed, units;
  logic [PW-1:0] prod;
  logic [COST_W:0] sum;
  logic [COST_W-1:0] fee, paid, paid_n, paid_upd, cost_n, change_n;
  logic [HW-1:0] hold, hold_n;
  logic cost_valid_n, bout_n, car_left_n, tkt_ready_n;
  assign elapsed  = now_time - tkt_q;
  assign units    = (elapsed == '0) ? TW'(1) : elapsed;
  assign prod     = PW'(units) * PW'(FEE_PER_UNIT);
  assign fee      = (|prod[PW-1:COST_W]) ? '1 : prod[COST_W-1:0];
  assign sum      = {1'b0, paid} + {1'b0, pay_amount};
  assign paid_upd = !pay_valid ? paid : (sum[COST_W] ? '1 : sum[COST_W-1:0]);
  // next-state and next registered outputs; every output is a flop fed from here
  always_comb begin
    state_n      = state;
    tkt_q_n      = tkt_q;
    paid_n       = paid;
    cost_n       = cost;
    cost_valid_n = cost_valid;
    change_n     = change;
    bout_n       = bout;
    hold_n       = hold;
    car_left_n   = 1'b0;
    case (state)
      IDLE: state_n = sout ? WAIT_TKT : IDLE;
      WAIT_TKT: begin
        if (tkt_valid) begin
          tkt_q_n = tkt_time;
          state_n = CALC;
        end else if (!sout) state_n = IDLE;
      end
      CALC: begin
        cost_valid_n = 1'b1;
        if (GRACE_ON && elapsed <= TW'(GRACE)) begin
          cost_n   = '0;
          change_n = '0;
          bout_n   = 1'b1;
          hold_n   = HW'(BAR_HOLD);
          state_n  = OPEN;
        end else begin
          cost_n  = fee;
          state_n = WAIT_PAY;
        end
      end
      WAIT_PAY: begin
        paid_n = paid_upd;
        if (pay_valid && paid_upd >= cost) begin
          change_n = paid_upd - cost;
          bout_n   = 1'b1;
          hold_n   = HW'(BAR_HOLD);
          state_n  = OPEN;
        end else if (!sout && paid_upd == '0) begin
          cost_n       = '0;
          cost_valid_n = 1'b0;
          state_n      = IDLE;
        end
      end
      OPEN: begin
        if (sout) hold_n = HW'(BAR_HOLD);
        else if (hold <= HW'(1)) begin
          car_left_n   = 1'b1;
          bout_n       = 1'b0;
          cost_n       = '0;
          cost_valid_n = 1'b0;
          change_n     = '0;
          paid_n       = '0;
          hold_n       = '0;
          state_n      = IDLE;
        end else hold_n = hold - HW'(1);
      end
      default: state_n = IDLE;
    endcase
    tkt_ready_n = (state_n == WAIT_TKT);
  end
  // state and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      tkt_q      <= '0;
      paid       <= '0;
      cost       <= '0;
      cost_valid <= 1'b0;
      change     <= '0;
      bout       <= 1'b0;
      hold       <= '0;
      car_left   <= 1'b0;
      tkt_ready  <= 1'b0;
    end else begin
      state      <= state_n;
      tkt_q      <= tkt_q_n;
      paid       <= paid_n;
      cost       <= cost_n;
      cost_valid <= cost_valid_n;
      change     <= change_n;
      bout       <= bout_n;
      hold       <= hold_n;
      car_left   <= car_left_n;
      tkt_ready  <= tkt_ready_n;
    end
  end
endmodule

// File: tb/tb_park_exit_cashier.sv
// tb_park_exit_cashier: directed vectors with hand-computed fees, change and bar timing
module tb_park_exit_cashier;
  logic clk = 1'b0, rst = 1'b0, sout = 1'b0, tkt_valid = 1'b0, pay_valid = 1'b0;
  logic [15:0] now_time = '0, tkt_time = '0, pay_amount = '0;
  logic tkt_ready, cost_valid, bout, car_left;
  logic [15:0] cost, change;
  int total = 0, passed = 0;
  park_exit_cashier dut (
    .clk(clk), .rst(rst), .sout(sout), .now_time(now_time), .tkt_valid(tkt_valid),
    .tkt_time(tkt_time), .tkt_ready(tkt_ready), .pay_valid(pay_valid), .pay_amount(pay_amount),
    .cost(cost), .cost_valid(cost_valid), .change(change), .bout(bout), .car_left(car_left)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else passed++;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic enter(input logic [15:0] t, input logic [15:0] n);
    sout = 1'b1;
    tick();
    tkt_valid = 1'b1;
    tkt_time = t;
    now_time = n;
    tick();
    tkt_valid = 1'b0;
    tick();
  endtask
  task automatic pay(input logic [15:0] amt);
    pay_valid = 1'b1;
    pay_amount = amt;
    tick();
    pay_valid = 1'b0;
  endtask
  task automatic leave(input int exp_n);
    int n = 0;
    sout = 1'b0;
    do begin
      tick();
      n++;
    end while (!car_left && n < 40);
    chk("hold_cycles", n, exp_n);
    chk("car_left_pulse", car_left, 1);
    chk("bout_closed", bout, 0);
    chk("cost_valid_clr", cost_valid, 0);
    chk("change_clr", change, 0);
    tick();
    chk("car_left_one_cycle", car_left, 0);
  endtask
  initial begin
    logic seen;
    tick();
    tick();
    chk("rst_bout", bout, 0);
    chk("rst_cost_valid", cost_valid, 0);
    chk("rst_cost", cost, 0);
    chk("rst_tkt_ready", tkt_ready, 0);
    chk("rst_car_left", car_left, 0);
    rst = 1'b1;
    tick();
    sout = 1'b1;
    tick();
    chk("n_tkt_ready", tkt_ready, 1);
    tkt_valid = 1'b1;
    tkt_time = 16'd40;
    now_time = 16'd100;
    tick();
    tkt_valid = 1'b0;
    chk("n_ready_drop", tkt_ready, 0);
    chk("n_calc_no_valid", cost_valid, 0);
    tick();
    chk("n_cost", cost, 120);
    chk("n_cost_valid", cost_valid, 1);
    pay(16'd100);
    chk("n_partial_bout", bout, 0);
    pay(16'd50);
    chk("n_bout", bout, 1);
    chk("n_change", change, 30);
    leave(8);
    enter(16'hFFF0, 16'h0010);
    chk("wrap_cost", cost, 64);
    sout = 1'b0;
    tick();
    chk("pay_abort_cost_valid", cost_valid, 0);
    chk("pay_abort_cost", cost, 0);
    sout = 1'b1;
    tick();
    chk("abort_tkt_ready", tkt_ready, 1);
    sout = 1'b0;
    tick();
    chk("abort_ready_drop", tkt_ready, 0);
    seen = 1'b0;
    tkt_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      seen |= bout | car_left | tkt_ready | cost_valid;
    end
    tkt_valid = 1'b0;
    chk("abort_quiet", seen, 0);
    enter(16'd1, 16'd10);
    chk("r_cost", cost, 18);
    pay(16'd20);
    chk("r_bout", bout, 1);
    chk("r_change", change, 2);
    sout = 1'b0;
    rst = 1'b0;
    tick();
    chk("r_bout_clr", bout, 0);
    chk("r_cost_valid_clr", cost_valid, 0);
    chk("r_no_car_left", car_left, 0);
    rst = 1'b1;
    tick();
    chk("r_still_no_car_left", car_left, 0);
    chk("r_idle_bout", bout, 0);
    enter(16'd1, 16'd0);
    chk("sat_cost", cost, 16'hFFFF);
    pay(16'd5);
    chk("sat_partial_bout", bout, 0);
    pay(16'hFFFF);
    chk("sat_bout", bout, 1);
    chk("sat_change", change, 0);
    leave(8);
    enter(16'd20, 16'd23);
`ifdef PARK_GRACE_EN
    chk("grace_cost", cost, 0);
    chk("grace_bout", bout, 1);
    chk("grace_change", change, 0);
    chk("grace_cost_valid", cost_valid, 1);
`else
    chk("grace_cost", cost, 6);
    chk("grace_wait_bout", bout, 0);
    chk("grace_cost_valid", cost_valid, 1);
    pay(16'd6);
    chk("grace_paid_bout", bout, 1);
    chk("grace_change", change, 0);
`endif
    leave(8);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
